// File: rtl/simple_median_pkg.sv
// Shared types and constants for the binary 3x3 median filter / activity detector.
package simple_median_pkg;

  localparam int IMG_W_DEF       = 240;
  localparam int IMG_H_DEF       = 180;
  localparam int MEDIAN_MAJORITY = 5;
  localparam int COUNT_W         = 13;
  localparam int NEIGH_N         = 9;
  localparam logic [3:0] CENTRE_IDX = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EVAL, S_DONE} state_t;

  // Two's-complement offsets: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1
  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } offset_t;

  // Neighbour visit order: x-major, y-minor, matching the 9 READ cycles
  function automatic offset_t neigh_ofs(input logic [3:0] idx);
    offset_t o;
    o = '{dx: 2'b00, dy: 2'b00};
    case (idx)
      4'd0: o = '{dx: 2'b11, dy: 2'b11};
      4'd1: o = '{dx: 2'b11, dy: 2'b00};
      4'd2: o = '{dx: 2'b11, dy: 2'b01};
      4'd3: o = '{dx: 2'b00, dy: 2'b11};
      4'd4: o = '{dx: 2'b00, dy: 2'b00};
      4'd5: o = '{dx: 2'b00, dy: 2'b01};
      4'd6: o = '{dx: 2'b01, dy: 2'b11};
      4'd7: o = '{dx: 2'b01, dy: 2'b00};
      4'd8: o = '{dx: 2'b01, dy: 2'b01};
      default: o = '{dx: 2'b00, dy: 2'b00};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/simple_median_top_addr_gen.sv
// Neighbour address generator: centre + table offset, clamped to the centre when outside the frame.
module median_window_addr_gen
  import simple_median_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic [7:0] cx,
  input  logic [7:0] cy,
  input  logic [3:0] idx,
  output logic [7:0] ax,
  output logic [7:0] ay,
  output logic       in_frame
);

  offset_t    o;
  logic [9:0] nx, ny;
  logic       in_x, in_y;

  // 10-bit arithmetic so that -1 from coordinate 0 shows up as a set sign bit
  always_comb begin
    o        = neigh_ofs(idx);
    nx       = {2'b00, cx} + {{8{o.dx[1]}}, o.dx};
    ny       = {2'b00, cy} + {{8{o.dy[1]}}, o.dy};
    in_x     = !nx[9] && (nx[8:0] < 9'(IMG_W));
    in_y     = !ny[9] && (ny[8:0] < 9'(IMG_H));
    in_frame = in_x && in_y;
    ax       = in_frame ? nx[7:0] : cx;
    ay       = in_frame ? ny[7:0] : cy;
  end

endmodule

// File: rtl/simple_median_top.sv
// Binary 3x3 median filter and active-pixel counter over a bit-addressed frame.
// Optional `SIMPLE_MEDIAN_ACTIVE_COUNT_OUT_EN exposes the live counter as activeWindows.
module simple_median_top
  import simple_median_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               binaryDataIn,
  input  logic               start,
  input  logic [COUNT_W-1:0] threshold,
  output logic               wakeUp,
  output logic               writeMedianMem,
  output logic               writeMedianData,
  output logic               fullImageDone,
  output logic [7:0]         xAddressOut,
  output logic [7:0]         yAddressOut,
  output logic               binaryMemWriteEnable
`ifdef SIMPLE_MEDIAN_ACTIVE_COUNT_OUT_EN
  ,
  output logic [COUNT_W-1:0] activeWindows
`endif
);

  state_t             state;
  logic [7:0]         cx, cy;
  logic [3:0]         idx;
  logic [3:0]         ones;
  logic               in_d;
  logic [COUNT_W-1:0] count;
  logic               wake;

  logic [7:0] ax, ay;
  logic       in_frame;
  logic [3:0] gen_idx;
  logic [3:0] total;
  logic       median, last_px, scanning;

  assign gen_idx = (state == S_EVAL) ? CENTRE_IDX : idx;

  median_window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_addr (
    .cx       (cx),
    .cy       (cy),
    .idx      (gen_idx),
    .ax       (ax),
    .ay       (ay),
    .in_frame (in_frame)
  );

  // in_d is the in-frame flag of the address issued last cycle, aligned with its data
  always_comb begin
    total    = ones + {3'b000, in_d & binaryDataIn};
    median   = (total >= 4'(MEDIAN_MAJORITY));
    last_px  = (cx == 8'(IMG_W - 1)) && (cy == 8'(IMG_H - 1));
    scanning = (state == S_READ) || (state == S_EVAL);
  end

  assign xAddressOut          = scanning ? ax : 8'd0;
  assign yAddressOut          = scanning ? ay : 8'd0;
  assign writeMedianMem       = (state == S_EVAL) && start;
  assign writeMedianData      = writeMedianMem && median;
  assign fullImageDone        = (state == S_DONE);
  assign binaryMemWriteEnable = (state == S_IDLE) && !start;
  assign wakeUp               = wake;
`ifdef SIMPLE_MEDIAN_ACTIVE_COUNT_OUT_EN
  assign activeWindows        = count;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cx    <= '0;
      cy    <= '0;
      idx   <= '0;
      ones  <= '0;
      in_d  <= 1'b0;
      count <= '0;
      wake  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cx    <= '0;
            cy    <= '0;
            idx   <= '0;
            count <= '0;
            wake  <= 1'b0;
            state <= S_READ;
          end
        end
        S_READ: begin
          if (!start) begin
            count <= '0;
            state <= S_IDLE;
          end else begin
            // Data arriving in the idx-0 cycle belongs to the previous centre read
            ones <= (idx == 4'd0) ? 4'd0 : total;
            in_d <= in_frame;
            idx  <= idx + 4'd1;
            if (idx == 4'd8) state <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (!start) begin
            count <= '0;
            state <= S_IDLE;
          end else begin
            if (median && (count != '1)) count <= count + 1'b1;
            idx <= '0;
            if (cy == 8'(IMG_H - 1)) begin
              cy <= '0;
              cx <= cx + 8'd1;
            end else begin
              cy <= cy + 8'd1;
            end
            state <= last_px ? S_DONE : S_READ;
          end
        end
        S_DONE: begin
          wake <= (count > threshold);
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_median_top.sv
// Directed scoreboard bench for simple_median_top on a reduced frame.
module tb_simple_median_top;

  localparam int W = 16;
  localparam int H = 14;
  localparam int N = W * H * 10;

  typedef struct {
    int x;
    int y;
    bit d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        binaryDataIn;
  logic        start;
  logic [12:0] threshold;
  logic        wakeUp, writeMedianMem, writeMedianData, fullImageDone;
  logic [7:0]  xAddressOut, yAddressOut;
  logic        binaryMemWriteEnable;
`ifdef SIMPLE_MEDIAN_ACTIVE_COUNT_OUT_EN
  logic [12:0] activeWindows;
`endif

  bit   mem [256][256];
  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail = 0;
  int   exp_cnt;

  simple_median_top #(.IMG_W(W), .IMG_H(H)) dut (
    .clk                  (clk),
    .reset                (reset),
    .binaryDataIn         (binaryDataIn),
    .start                (start),
    .threshold            (threshold),
    .wakeUp               (wakeUp),
    .writeMedianMem       (writeMedianMem),
    .writeMedianData      (writeMedianData),
    .fullImageDone        (fullImageDone),
    .xAddressOut          (xAddressOut),
    .yAddressOut          (yAddressOut),
    .binaryMemWriteEnable (binaryMemWriteEnable)
`ifdef SIMPLE_MEDIAN_ACTIVE_COUNT_OUT_EN
    ,
    .activeWindows        (activeWindows)
`endif
  );

  always #5 clk = ~clk;

  // External frame memory with one-cycle read latency
  always @(posedge clk) binaryDataIn <= mem[xAddressOut][yAddressOut];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic fill(input int mode);
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 256; y++) mem[x][y] = 1'b0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        case (mode)
          1: mem[x][y] = 1'b1;
          2: mem[x][y] = (x >= 10 && x <= 12 && y >= 10 && y <= 12);
          3: mem[x][y] = (x == 7 && y == 7);
          default: mem[x][y] = 1'b0;
        endcase
  endtask

  function automatic bit model_median(input int x, input int y);
    int c = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++)
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          c += int'(mem[x + dx][y + dy]);
    return c >= 5;
  endfunction

  // Pushes the whole frame's expectations, raises start, then checks each strobe as it appears
  task automatic run_frame(input int thr);
    exp_t e;
    int   c = 0, last = -1;
    bit   done = 0;
    exp_q.delete();
    exp_cnt = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        e = '{x: x, y: y, d: model_median(x, y)};
        exp_q.push_back(e);
        if (e.d && exp_cnt < 8191) exp_cnt++;
      end
    threshold = 13'(thr);
    chk("load_we", binaryMemWriteEnable, 1);
    start = 1'b1;
    while (!done && c < N + 50) begin
      @(negedge clk);
      c++;
      if (writeMedianMem) begin
        if (exp_q.size() == 0) chk("extra_strobe", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("med_x", xAddressOut, e.x);
          chk("med_y", yAddressOut, e.y);
          chk("med_data", writeMedianData, e.d);
          if (last < 0) chk("first_strobe_cycle", c, 10);
          else chk("strobe_period", c - last, 10);
          last = c;
        end
      end
      if (fullImageDone) done = 1;
    end
    chk("done_seen", done, 1);
    // c == 1 is the first READ cycle, so DONE entry lands N cycles later
    chk("done_cycle", c, N + 1);
    chk("missing_strobes", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("wakeup", wakeUp, (exp_cnt > thr));
  endtask

  task automatic stop_frame();
    start = 1'b0;
    @(negedge clk);
    chk("done_drop", fullImageDone, 0);
  endtask

  initial begin
    int strobes;
    reset = 1'b0;
    start = 1'b0;
    threshold = '0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_strobe", writeMedianMem, 0);
    chk("rst_data", writeMedianData, 0);
    chk("rst_done", fullImageDone, 0);
    chk("rst_wake", wakeUp, 0);
    chk("rst_x", xAddressOut, 0);
    chk("rst_y", yAddressOut, 0);
    chk("rst_we", binaryMemWriteEnable, 1);
    reset = 1'b1;
    @(negedge clk);

    fill(0); run_frame(0); stop_frame();
    fill(1); run_frame(50); stop_frame();
    chk("wake_hold", wakeUp, 1);
    fill(2); run_frame(4);
    threshold = 13'd5;
    repeat (2) @(negedge clk);
    chk("wake_thr5", wakeUp, 0);
    stop_frame();
    fill(3); run_frame(0); stop_frame();

    // Abort mid-scan, then restart from (0,0)
    fill(1);
    threshold = '0;
    start = 1'b1;
    repeat (500) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_strobe", writeMedianMem, 0);
    chk("abort_done", fullImageDone, 0);
    chk("abort_we", binaryMemWriteEnable, 1);
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (writeMedianMem || fullImageDone) strobes++;
    end
    chk("abort_quiet", strobes, 0);
    run_frame(0);

    // Asynchronous reset in the middle of a scan
    stop_frame();
    start = 1'b1;
    repeat (300) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mrst_strobe", writeMedianMem, 0);
    chk("mrst_data", writeMedianData, 0);
    chk("mrst_done", fullImageDone, 0);
    chk("mrst_wake", wakeUp, 0);
    chk("mrst_x", xAddressOut, 0);
    chk("mrst_y", yAddressOut, 0);
    chk("mrst_we_start_hi", binaryMemWriteEnable, 0);
    start = 1'b0;
    #1;
    chk("mrst_we_start_lo", binaryMemWriteEnable, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
